// File: rtl/onehot_decoder_pipe_pkg.sv
// Shared types and helpers for the one-hot decoder pipeline.
//   skid_state_t : occupancy of the 2-entry output skid buffer
//   decode_lane  : single-lane select -> {err, one-hot} decode
package onehot_decoder_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_t;

  // Widest one-hot lane the shared decode helper supports.
  localparam int unsigned MAX_OUTPUTS = 256;
  localparam int unsigned IDX_W       = $clog2(MAX_OUTPUTS);

  // The result is {err, y} in a fixed-width vector. Bit MAX_OUTPUTS is the
  // error flag, and bits [outputs-1:0] hold the one-hot code. Callers slice
  // out the part they need.
  function automatic logic [MAX_OUTPUTS:0] decode_lane(
    input int unsigned sel,
    input logic        en,
    input int unsigned outputs
  );
    logic [MAX_OUTPUTS:0] r;
    r = '0;
    if (en) begin
      if (sel < outputs) r[sel[IDX_W-1:0]] = 1'b1;
      else               r[MAX_OUTPUTS]    = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/onehot_decoder_pipe_if.sv
// Handshake bundle for onehot_decoder_pipe.
//   in_valid/in_ready/in_sel/in_en     : upstream select beat
//   out_valid/out_ready/out_y/out_err  : downstream decoded beat
// The slave modport is the decoder's view. The master modport is the
// environment's view, and it drives the input beat and out_ready.
interface onehot_decoder_pipe_if #(
  parameter int BITS    = 3,
  parameter int OUTPUTS = 1 << BITS,
  parameter int LANES   = 1
);
  logic                     in_valid;
  logic                     in_ready;
  logic [LANES*BITS-1:0]    in_sel;
  logic [LANES-1:0]         in_en;
  logic                     out_valid;
  logic                     out_ready;
  logic [LANES*OUTPUTS-1:0] out_y;
  logic [LANES-1:0]         out_err;

  modport slave (
    input  in_valid, in_sel, in_en, out_ready,
    output in_ready, out_valid, out_y, out_err
  );

  modport master (
    output in_valid, in_sel, in_en, out_ready,
    input  in_ready, out_valid, out_y, out_err
  );
endinterface

// File: rtl/onehot_decoder_pipe_skid2.sv
// Generic 2-entry skid buffer with a registered output.
//   clk, rst_n           : clock, async active-low reset
//   in_valid/in_ready    : push side; in_ready comes only from state
//   in_data              : WIDTH-bit payload
//   out_valid/out_ready  : pop side; out_data is held stable while stalled
//   out_data             : head entry
module onehot_decoder_skid2
  import onehot_decoder_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  skid_state_t      state_q, state_d;
  logic [WIDTH-1:0] head_q, spare_q;
  logic             push, pop;

  assign push     = in_valid && in_ready;
  assign pop      = out_valid && out_ready;
  assign out_data = head_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (push) state_d = ONE;
      ONE: begin
        if (push && !pop)      state_d = TWO;
        else if (!push && pop) state_d = EMPTY;
      end
      TWO:     if (pop) state_d = ONE;
      default: state_d = EMPTY;
    endcase
  end

  // Outputs depend on state only, so there is no out_ready -> in_ready path.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      EMPTY: in_ready = 1'b1;
      ONE: begin
        in_ready  = 1'b1;
        out_valid = 1'b1;
      end
      TWO:   out_valid = 1'b1;
      default: ;
    endcase
  end

  // Payload storage. The head is the presented beat. The spare entry
  // only fills while the head is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      spare_q <= '0;
    end else begin
      case (state_q)
        EMPTY: if (push) head_q <= in_data;
        ONE: begin
          if (push && pop) head_q  <= in_data;
          else if (push)   spare_q <= in_data;
        end
        TWO: if (pop) head_q <= spare_q;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/onehot_decoder_pipe.sv
// Multi-lane pipelined binary-to-one-hot decoder with range checking.
//   clk, rst_n : clock, async active-low reset
//   bus        : in_valid/in_ready/in_sel/in_en in, and
//                out_valid/out_ready/out_y/out_err out
//   err_count  : saturating count of accepted beats with any lane error
// Decode happens at input acceptance. The result then goes through a
// 2-entry skid buffer, which gives a registered, backpressure-tolerant output.
module onehot_decoder_pipe
  import onehot_decoder_pkg::*;
#(
  parameter int BITS    = 3,
  parameter int OUTPUTS = 1 << BITS,
  parameter int LANES   = 1,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  onehot_decoder_pipe_if.slave bus,
  output logic [CNT_W-1:0]   err_count
);

  if (BITS < 1) begin : g_bad_bits
    $error("onehot_decoder_pipe: BITS must be >= 1");
  end
  if (OUTPUTS < 1 || OUTPUTS > (1 << BITS)) begin : g_bad_outputs
    $error("onehot_decoder_pipe: OUTPUTS must be in 1 .. 2**BITS");
  end
  if (OUTPUTS > MAX_OUTPUTS) begin : g_too_wide
    $error("onehot_decoder_pipe: OUTPUTS exceeds decode helper width");
  end
  if (LANES < 1) begin : g_bad_lanes
    $error("onehot_decoder_pipe: LANES must be >= 1");
  end
  if (CNT_W < 1) begin : g_bad_cnt
    $error("onehot_decoder_pipe: CNT_W must be >= 1");
  end

  localparam int WIDTH = LANES * (OUTPUTS + 1);

  logic [LANES*OUTPUTS-1:0] dec_y;
  logic [LANES-1:0]         dec_err;
  logic [MAX_OUTPUTS:0]     lane_res;
  logic                     unused_res;
  logic                     accept;
  logic [WIDTH-1:0]         skid_out;

  // The helper returns a fixed-width vector. Only [OUTPUTS-1:0] and the
  // error bit are kept; the rest is folded into unused_res.
  always_comb begin
    dec_y      = '0;
    dec_err    = '0;
    lane_res   = '0;
    unused_res = 1'b0;
    for (int unsigned k = 0; k < LANES; k++) begin
      lane_res   = decode_lane(32'(bus.in_sel[k*BITS +: BITS]), bus.in_en[k],
                               OUTPUTS);
      dec_y[k*OUTPUTS +: OUTPUTS] = lane_res[OUTPUTS-1:0];
      dec_err[k] = lane_res[MAX_OUTPUTS];
      unused_res = unused_res ^ (^lane_res);
    end
  end

  onehot_decoder_skid2 #(
    .WIDTH(WIDTH)
  ) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (bus.in_valid),
    .in_ready (bus.in_ready),
    .in_data  ({dec_err, dec_y}),
    .out_valid(bus.out_valid),
    .out_ready(bus.out_ready),
    .out_data (skid_out)
  );

  assign bus.out_y   = skid_out[LANES*OUTPUTS-1:0];
  assign bus.out_err = skid_out[WIDTH-1 -: LANES];

  assign accept = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_count <= '0;
    else if (accept && (|dec_err) && (err_count != '1))
      err_count <= err_count + 1'b1;
  end

endmodule

// File: tb/tb_onehot_decoder_pipe.sv
module tb_onehot_decoder_pipe;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] cnt0;
  logic [1:0] cnt1;
  int         n_vec = 0;
  int         n_miss = 0;

  always #5 clk = ~clk;

  // Default configuration
  onehot_decoder_pipe_if #(.BITS(3), .OUTPUTS(8), .LANES(1)) bus0 ();
  onehot_decoder_pipe #(.BITS(3), .OUTPUTS(8), .LANES(1), .CNT_W(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0.slave), .err_count(cnt0)
  );

  // Two lanes with a partial output range and a small counter
  onehot_decoder_pipe_if #(.BITS(3), .OUTPUTS(6), .LANES(2)) bus1 ();
  onehot_decoder_pipe #(.BITS(3), .OUTPUTS(6), .LANES(2), .CNT_W(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1.slave), .err_count(cnt1)
  );

  task automatic test_reset;
    repeat (2) @(negedge clk);
    n_vec++; if (bus0.out_valid !== 1'b0) begin n_miss++; $display("FAIL rst_valid0: got %b want 0", bus0.out_valid); end
    n_vec++; if (bus0.out_y !== 8'h00) begin n_miss++; $display("FAIL rst_y0: got %h want 00", bus0.out_y); end
    n_vec++; if (bus0.out_err !== 1'b0) begin n_miss++; $display("FAIL rst_err0: got %b want 0", bus0.out_err); end
    n_vec++; if (cnt0 !== 8'd0) begin n_miss++; $display("FAIL rst_cnt0: got %0d want 0", cnt0); end
    n_vec++; if (bus1.out_valid !== 1'b0) begin n_miss++; $display("FAIL rst_valid1: got %b want 0", bus1.out_valid); end
    n_vec++; if (bus1.out_y !== 12'h000) begin n_miss++; $display("FAIL rst_y1: got %h want 000", bus1.out_y); end
    n_vec++; if (cnt1 !== 2'd0) begin n_miss++; $display("FAIL rst_cnt1: got %0d want 0", cnt1); end
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++; if (bus0.in_ready !== 1'b1) begin n_miss++; $display("FAIL rst_ready0: got %b want 1", bus0.in_ready); end
    n_vec++; if (bus1.in_ready !== 1'b1) begin n_miss++; $display("FAIL rst_ready1: got %b want 1", bus1.in_ready); end
  endtask

  // Default config, back-to-back beats at full rate
  task automatic test_single;
    logic [2:0] sel [4] = '{3'd5, 3'd0, 3'd7, 3'd3};
    logic       en  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [7:0] ey  [4] = '{8'b0010_0000, 8'b0000_0001, 8'b1000_0000, 8'h00};
    bus0.out_ready = 1'b1;
    for (int i = 0; i <= 4; i++) begin
      if (i > 0) begin
        n_vec++; if (bus0.out_valid !== 1'b1) begin n_miss++; $display("FAIL single_valid[%0d]: got %b want 1", i-1, bus0.out_valid); end
        n_vec++; if (bus0.out_y !== ey[i-1]) begin n_miss++; $display("FAIL single_y[%0d]: got %h want %h", i-1, bus0.out_y, ey[i-1]); end
        n_vec++; if (bus0.out_err !== 1'b0) begin n_miss++; $display("FAIL single_err[%0d]: got %b want 0", i-1, bus0.out_err); end
      end
      if (i < 4) begin
        bus0.in_valid = 1'b1; bus0.in_sel = sel[i]; bus0.in_en = en[i];
      end else begin
        bus0.in_valid = 1'b0;
      end
      @(negedge clk);
    end
    n_vec++; if (bus0.out_valid !== 1'b0) begin n_miss++; $display("FAIL single_drain: got %b want 0", bus0.out_valid); end
    n_vec++; if (cnt0 !== 8'd0) begin n_miss++; $display("FAIL single_cnt: got %0d want 0", cnt0); end
  endtask

  // Partial range: sel >= 6 in an enabled lane flags err
  task automatic test_range;
    logic [5:0]  sel [4] = '{{3'd7, 3'd2}, {3'd5, 3'd6}, {3'd7, 3'd7}, {3'd0, 3'd1}};
    logic [1:0]  en  [4] = '{2'b11, 2'b11, 2'b00, 2'b01};
    logic [11:0] ey  [4] = '{{6'b0, 6'b000100}, {6'b100000, 6'b0}, 12'h000, {6'b0, 6'b000010}};
    logic [1:0]  ee  [4] = '{2'b10, 2'b01, 2'b00, 2'b00};
    logic [1:0]  ec  [4] = '{2'd1, 2'd2, 2'd2, 2'd2};
    bus1.out_ready = 1'b1;
    for (int i = 0; i <= 4; i++) begin
      if (i > 0) begin
        n_vec++; if (bus1.out_valid !== 1'b1) begin n_miss++; $display("FAIL range_valid[%0d]: got %b want 1", i-1, bus1.out_valid); end
        n_vec++; if (bus1.out_y !== ey[i-1]) begin n_miss++; $display("FAIL range_y[%0d]: got %h want %h", i-1, bus1.out_y, ey[i-1]); end
        n_vec++; if (bus1.out_err !== ee[i-1]) begin n_miss++; $display("FAIL range_err[%0d]: got %b want %b", i-1, bus1.out_err, ee[i-1]); end
        n_vec++; if (cnt1 !== ec[i-1]) begin n_miss++; $display("FAIL range_cnt[%0d]: got %0d want %0d", i-1, cnt1, ec[i-1]); end
      end
      if (i < 4) begin
        bus1.in_valid = 1'b1; bus1.in_sel = sel[i]; bus1.in_en = en[i];
      end else begin
        bus1.in_valid = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  // Stall with A, B, C offered back-to-back; C must wait for space
  task automatic test_back_to_back;
    bus0.out_ready = 1'b0;
    bus0.in_valid = 1'b1; bus0.in_en = 1'b1; bus0.in_sel = 3'd1;   // A
    @(negedge clk);
    n_vec++; if (bus0.out_y !== 8'h02 || bus0.out_valid !== 1'b1) begin n_miss++; $display("FAIL b2b_a: got v=%b y=%h want v=1 y=02", bus0.out_valid, bus0.out_y); end
    n_vec++; if (bus0.in_ready !== 1'b1) begin n_miss++; $display("FAIL b2b_ready_one: got %b want 1", bus0.in_ready); end
    bus0.in_sel = 3'd3;                                              // B
    @(negedge clk);
    n_vec++; if (bus0.in_ready !== 1'b0) begin n_miss++; $display("FAIL b2b_ready_two: got %b want 0", bus0.in_ready); end
    n_vec++; if (bus0.out_y !== 8'h02) begin n_miss++; $display("FAIL b2b_stall1: got %h want 02", bus0.out_y); end
    bus0.in_sel = 3'd6;                                              // C
    @(negedge clk);
    n_vec++; if (bus0.out_y !== 8'h02 || bus0.out_valid !== 1'b1) begin n_miss++; $display("FAIL b2b_stall2: got v=%b y=%h want v=1 y=02", bus0.out_valid, bus0.out_y); end
    n_vec++; if (bus0.in_ready !== 1'b0) begin n_miss++; $display("FAIL b2b_hold_c: got %b want 0", bus0.in_ready); end
    bus0.out_ready = 1'b1;
    @(negedge clk);
    n_vec++; if (bus0.out_y !== 8'h08 || bus0.out_valid !== 1'b1) begin n_miss++; $display("FAIL b2b_b: got v=%b y=%h want v=1 y=08", bus0.out_valid, bus0.out_y); end
    n_vec++; if (bus0.in_ready !== 1'b1) begin n_miss++; $display("FAIL b2b_ready_after: got %b want 1", bus0.in_ready); end
    @(negedge clk);
    n_vec++; if (bus0.out_y !== 8'h40 || bus0.out_valid !== 1'b1) begin n_miss++; $display("FAIL b2b_c: got v=%b y=%h want v=1 y=40", bus0.out_valid, bus0.out_y); end
    bus0.in_valid = 1'b0;
    @(negedge clk);
    n_vec++; if (bus0.out_valid !== 1'b0) begin n_miss++; $display("FAIL b2b_drain: got %b want 0", bus0.out_valid); end
  endtask

  // 2-bit counter: 1, 2, 3, then it holds at 3
  task automatic test_saturation;
    logic [1:0] ec [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bus1.out_ready = 1'b1;
    bus1.in_valid = 1'b1; bus1.in_en = 2'b11; bus1.in_sel = {3'd6, 3'd0};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_vec++; if (cnt1 !== ec[i]) begin n_miss++; $display("FAIL sat_cnt[%0d]: got %0d want %0d", i, cnt1, ec[i]); end
      n_vec++; if (bus1.out_y !== 12'h001 || bus1.out_err !== 2'b10) begin n_miss++; $display("FAIL sat_beat[%0d]: got y=%h e=%b want y=001 e=10", i, bus1.out_y, bus1.out_err); end
    end
    bus1.in_valid = 1'b0;
    @(negedge clk);
  endtask

  // Reset while the buffer is full, with input still offered
  task automatic test_reset_mid;
    bus1.out_ready = 1'b0;
    bus1.in_valid = 1'b1; bus1.in_en = 2'b11; bus1.in_sel = {3'd7, 3'd3};
    repeat (2) @(negedge clk);
    n_vec++; if (bus1.in_ready !== 1'b0) begin n_miss++; $display("FAIL mid_full: got %b want 0", bus1.in_ready); end
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (bus1.out_valid !== 1'b0) begin n_miss++; $display("FAIL mid_valid: got %b want 0", bus1.out_valid); end
    n_vec++; if (cnt1 !== 2'd0) begin n_miss++; $display("FAIL mid_cnt: got %0d want 0", cnt1); end
    n_vec++; if (bus1.out_y !== 12'h000 || bus1.out_err !== 2'b00) begin n_miss++; $display("FAIL mid_data: got y=%h e=%b want y=000 e=00", bus1.out_y, bus1.out_err); end
    @(negedge clk);
    bus1.in_valid = 1'b0;
    bus1.out_ready = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++; if (bus1.in_ready !== 1'b1) begin n_miss++; $display("FAIL mid_ready: got %b want 1", bus1.in_ready); end
    for (int i = 0; i < 3; i++) begin
      n_vec++; if (bus1.out_valid !== 1'b0) begin n_miss++; $display("FAIL mid_stale[%0d]: got %b want 0", i, bus1.out_valid); end
      @(negedge clk);
    end
  endtask

  initial begin
    bus0.in_valid = 1'b0; bus0.in_sel = '0; bus0.in_en = '0; bus0.out_ready = 1'b0;
    bus1.in_valid = 1'b0; bus1.in_sel = '0; bus1.in_en = '0; bus1.out_ready = 1'b0;
    test_reset;
    test_single;
    test_range;
    test_back_to_back;
    test_saturation;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/onehot_decoder_pipe.md
Name: onehot_decoder_pipe

Overview:
- Multi-lane, pipelined binary-to-one-hot decoder with valid/ready flow control and range checking.
- Generalised successor of the single-lane combinational decoder: lane count, output count and non-power-of-two output ranges are parameters.
- Registered, backpressure-tolerant output.
- Sits between a select-producing control stage and downstream enable/mux logic.

Parameters:
- BITS, 3, select width per lane; must be >= 1.
- OUTPUTS, 1 << BITS, one-hot width per lane; must satisfy 1 <= OUTPUTS <= (1 << BITS).
- LANES, 1, number of independent decode lanes per beat; must be >= 1.
- CNT_W, 8, width of the saturating error counter; must be >= 1.

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous reset, active low
- in_valid  input  1  input beat valid
- in_ready  output  1  block can accept a beat
- in_sel  input  LANES*BITS  per-lane select; lane k occupies bits [k*BITS +: BITS]
- in_en  input  LANES  per-lane decode enable
- out_valid  output  1  output beat valid
- out_ready  input  1  downstream accepts beat
- out_y  output  LANES*OUTPUTS  per-lane one-hot; lane k occupies bits [k*OUTPUTS +: OUTPUTS]
- out_err  output  LANES  per-lane out-of-range flag for the presented beat
- err_count  output  CNT_W  saturating count of accepted beats with any lane error

Behaviour:
- One clock (clk) only. Reset is asynchronous, active low (rst_n).
- Elaboration checks, using generate-if with $error:
  - BITS < 1
  - OUTPUTS < 1 or OUTPUTS > (1 << BITS)
  - LANES < 1
  - CNT_W < 1
- Reset values:
  - out_valid = 0, out_y = 0, out_err = 0, err_count = 0
  - skid state = EMPTY, so in_ready = 1 one cycle after rst_n deasserts
- Reset asserted mid-operation discards all buffered beats immediately. No output beat is produced for them.
- Handshake:
  - A transfer occurs on a rising edge with valid && ready on that interface.
  - in_ready depends only on registered state; it has no combinational path from out_ready.
  - out_valid, out_y and out_err stay stable while out_valid && !out_ready.
- Per-lane decode, computed at input acceptance:
  - in_en[k] = 0: y = 0, err = 0.
  - in_en[k] = 1 and sel < OUTPUTS: y = 1 << sel, err = 0.
  - in_en[k] = 1 and sel >= OUTPUTS: y = 0, err = 1. This case is reachable only when OUTPUTS < 2^BITS.
- Latency: 1 cycle from input acceptance to out_valid when the buffer is EMPTY.
- Skid buffer, 2 entries, states EMPTY, ONE, TWO:
  - EMPTY: in_ready = 1; accept -> ONE.
  - ONE:
    - in_ready = 1
    - accept and !pop -> TWO
    - accept and pop -> ONE; new beat presented next cycle
    - pop only -> EMPTY
    - neither -> ONE
  - TWO:
    - in_ready = 0; input is ignored even if in_valid = 1
    - pop -> ONE; the second entry moves to the output
  - pop = out_valid && out_ready.
  - Beats leave in order; none are lost or duplicated.
- Sustained throughput is 1 beat/cycle when out_ready = 1 continuously.
- err_count:
  - Increments by 1 on each input acceptance where any computed err bit is 1.
  - Saturates at 2^CNT_W - 1; no wrap.
  - Cleared only by reset.

Decomposition:
- Package onehot_decoder_pkg:
  - enum typedef skid_state_t {EMPTY, ONE, TWO}
  - function decode_lane(sel, en) returning {err, y}, parameterised via BITS and OUTPUTS arguments or a let
- Sub-module onehot_decoder_skid2: generic 2-entry skid buffer, parameter WIDTH = LANES*(OUTPUTS+1). Instantiated once.
- Decode and error counter live in the top module.

Test Plan:
- Defaults, out_ready = 1, one beat in_sel = 3'd5, in_en = 1 -> next cycle out_valid = 1, out_y = 8'b0010_0000, out_err = 0, err_count = 0.
- BITS = 3, OUTPUTS = 6, LANES = 2; beat sel = {3'd7, 3'd2}, en = 2'b11 -> out_y = {6'b0, 6'b000100}, out_err = 2'b10, err_count = 1.
- out_ready = 0 while sending beats A, B, C back-to-back:
  - A and B accepted; in_ready = 0 after the second acceptance; C held.
  - Raise out_ready -> outputs A, B, C in order; out_y stable during stall.
- CNT_W = 2; five consecutive error beats -> err_count sequence 1, 2, 3, 3, 3.
- Assert rst_n = 0 with state TWO, mid-stream -> out_valid = 0, err_count = 0 immediately; after release in_ready = 1 and no stale beat appears.
- Elaborate with OUTPUTS = 9, BITS = 3 -> elaboration $error raised.
